ccff_bitstream_loader: RTL and testbench
========================================

Name: ccff_bitstream_loader

Overview:
- Upstream feeder of the configuration-chain memories in a routing tile.
- Accepts bitstream words over a valid/ready stream and serialises them one bit per cycle onto the chain's `ccff_head`.
- Drives a shift-enable that gates every `_mem` flop in the chain.
- Counts bits against the chain length and flags completion; optionally captures the old chain contents emerging at `ccff_tail` as readback words.

Parameters:
- WORD_W, 8, bitstream word width; the bit count per word (1..WORD_W) is carried on a sideband port.
- CHAIN_LEN, 36, total configuration bits in the chain (default = 9 ipin muxes x 4 SRAM bits).
- CNT_W, 16, width of the bit counter; must satisfy 2^CNT_W > CHAIN_LEN.

Ports:
- prog_clk  input  1  programming clock; all logic is on the rising edge.
- prog_reset_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE or DONE.
- bs_data  input  WORD_W  bitstream word; bit 0 is shifted first.
- bs_valid  input  1  bs_data is valid.
- bs_ready  output  1  loader accepts bs_data this cycle.
- ccff_head  output  1  serial configuration bit into the chain.
- ccff_shift_en  output  1  chain flops capture on this prog_clk edge.
- ccff_tail  input  1  serial output of the chain's last flop.
- busy  output  1  a load is in progress.
- done  output  1  CHAIN_LEN bits shifted; held until the next start.
- bit_cnt  output  CNT_W  bits shifted so far in the current load.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state = IDLE.
  - bs_ready, ccff_head, ccff_shift_en, busy, done = 0.
  - bit_cnt = 0; shift register = 0.
  - Reset mid-load aborts immediately; shift_en drops in the same instant, and the chain keeps partial contents.
- All outputs are registered except bs_ready, which is decoded from state.
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE / DONE:
  - bs_ready = 0 and ccff_shift_en = 0.
  - start -> LOAD; clear bit_cnt and done; set busy.
  - start in any other state is ignored.
- LOAD:
  - bs_ready = 1.
  - On bs_valid & bs_ready: capture bs_data into the shift register.
  - Set word_bits = min(WORD_W, CHAIN_LEN - bit_cnt), then -> SHIFT.
  - Without bs_valid, stay in LOAD with shift_en = 0; the chain holds state.
- SHIFT:
  - Each cycle: ccff_head = sreg[0] and ccff_shift_en = 1 in the same cycle.
  - sreg shifts right by 1; bit_cnt and the local word-bit counter increment.
  - After word_bits bits: if bit_cnt == CHAIN_LEN -> DONE (busy = 0, done = 1); else -> LOAD.
- Timing:
  - A word costs (bits + 1) cycles: one accept cycle plus one cycle per bit.
  - First shift_en is asserted the cycle after the handshake.
- Final word: only the low (CHAIN_LEN mod WORD_W) bits are used when the remainder is nonzero; the upper bits are discarded.
- Extra words: no words are accepted outside LOAD, so an upstream surplus stays stalled on bs_ready = 0.
- bit_cnt saturates at CHAIN_LEN and never wraps.
- ccff_head holds its last value when shift_en = 0; chain behaviour does not depend on it then.

Optional Feature:
- Macro: CCFF_READBACK_EN.
- When defined, two outputs are added:
  - rb_data (WORD_W): readback word.
  - rb_valid (1): one-cycle pulse, no backpressure.
- Readback capture:
  - ccff_tail is sampled in every cycle where ccff_shift_en = 1, i.e. the old chain bit before the edge.
  - Samples are packed LSB-first.
  - rb_valid pulses the cycle after each full WORD_W samples.
  - A final partial word is emitted zero-padded in the cycle done rises.
  - Reset clears rb_data and rb_valid.
- When not defined: the ports are absent and ccff_tail is unused (no logic).

Test Plan:
- Full load (CHAIN_LEN = 36, WORD_W = 8): words 0xA5, 0x3C, 0xFF, 0x00, 0x09 offered back-to-back.
  - Expect 36 shift_en cycles in 41 total after the first handshake.
  - Head sequence starts 1,0,1,0,0,1,0,1.
  - done = 1 with bit_cnt = 36.
  - A 36-bit chain model holds 0x9_00FF_3CA5.
- Stall: bs_valid deasserted for 5 cycles between words 2 and 3.
  - shift_en = 0 and bs_ready = 1 throughout the gap.
  - Final chain contents are identical to the unstalled case.
- Partial last word: last word 0xF6.
  - Only bits 0..3 (0,1,1,0) are shifted.
  - bs_ready = 0 after done, with the 6th word still pending.
- Reset mid-SHIFT: assert prog_reset_n = 0 at bit 13.
  - Outputs go to reset values asynchronously.
  - A subsequent start reloads cleanly, with bit_cnt restarting at 0.
- Start while busy: pulse start at bit 20.
  - Ignored; load completes at 36 bits.
  - A start in DONE clears done and begins a new load.
- CCFF_READBACK_EN: chain model preloaded with 0x5_1234_ABCD.
  - rb_data sequence is 0xCD, 0xAB, 0x34, 0x12, 0x05.
  - The 5th rb_valid is coincident with done rising.

Source files
------------

// File: rtl/ccff_bitstream_loader_if.sv
// Bitstream word stream between an upstream feeder (master) and the CCFF loader (slave).
interface ccff_bitstream_loader_if #(
    parameter int unsigned WORD_W = 8
);
    logic [WORD_W-1:0] bs_data;
    logic              bs_valid;
    logic              bs_ready;

    modport master (
        output bs_data,
        output bs_valid,
        input  bs_ready
    );

    modport slave (
        input  bs_data,
        input  bs_valid,
        output bs_ready
    );
endinterface

// File: rtl/ccff_bitstream_loader.sv
// Serialises bitstream words onto a configuration chain (ccff_head / ccff_shift_en).
// Optional readback of the old chain contents at ccff_tail when CCFF_READBACK_EN is defined.
module ccff_bitstream_loader #(
    parameter int unsigned WORD_W    = 8,
    parameter int unsigned CHAIN_LEN = 36,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                      prog_clk,
    input  logic                      prog_reset_n,
    input  logic                      start,
    ccff_bitstream_loader_if.slave    bs,
    output logic                      ccff_head,
    output logic                      ccff_shift_en,
    input  logic                      ccff_tail,
    output logic                      busy,
    output logic                      done,
    output logic [CNT_W-1:0]          bit_cnt
`ifdef CCFF_READBACK_EN
    ,
    output logic [WORD_W-1:0]         rb_data,
    output logic                      rb_valid
`endif
);

    localparam int unsigned WB_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] CHAIN_LEN_C = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] WORD_W_C    = CNT_W'(WORD_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [WORD_W-1:0]  sreg_q, sreg_d;
    logic               head_q, head_d;
    logic               shift_en_q, shift_en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WB_W-1:0]    word_bits_q, word_bits_d;
    logic [WB_W-1:0]    word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0]   remain;
    logic               load_start;

    assign load_start = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start;

    // State register and datapath flops.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state_q     <= ST_IDLE;
            sreg_q      <= '0;
            head_q      <= 1'b0;
            shift_en_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            bit_cnt_q   <= '0;
            word_bits_q <= '0;
            word_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            head_q      <= head_d;
            shift_en_q  <= shift_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            bit_cnt_q   <= bit_cnt_d;
            word_bits_q <= word_bits_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    // Next-state logic. head/shift_en are registered, so each is set up on the
    // edge before the cycle in which the chain captures it.
    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        head_d      = head_q;
        shift_en_d  = 1'b0;
        busy_d      = busy_q;
        done_d      = done_q;
        bit_cnt_d   = bit_cnt_q;
        word_bits_d = word_bits_q;
        word_cnt_d  = word_cnt_q;
        remain      = CHAIN_LEN_C - bit_cnt_q;

        if (shift_en_q && (bit_cnt_q != CHAIN_LEN_C)) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_LOAD;
                    bit_cnt_d = '0;
                    done_d    = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            ST_LOAD: begin
                if (bs.bs_valid) begin
                    head_d      = bs.bs_data[0];
                    sreg_d      = bs.bs_data >> 1;
                    shift_en_d  = 1'b1;
                    word_bits_d = (remain >= WORD_W_C) ? WB_W'(WORD_W) : WB_W'(remain);
                    word_cnt_d  = WB_W'(1);
                    state_d     = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (word_cnt_q == word_bits_q) begin
                    if (bit_cnt_d == CHAIN_LEN_C) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    head_d     = sreg_q[0];
                    sreg_d     = sreg_q >> 1;
                    shift_en_d = 1'b1;
                    word_cnt_d = word_cnt_q + WB_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bs.bs_ready    = (state_q == ST_LOAD);
    assign ccff_head      = head_q;
    assign ccff_shift_en  = shift_en_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign bit_cnt        = bit_cnt_q;

`ifdef CCFF_READBACK_EN
    logic [WORD_W-1:0] rb_acc_q, rb_acc_d;
    logic [WORD_W-1:0] rb_word;
    logic [WB_W-1:0]   rb_cnt_q, rb_cnt_d;
    logic [WORD_W-1:0] rb_data_q, rb_data_d;
    logic              rb_valid_q, rb_valid_d;

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            rb_acc_q   <= '0;
            rb_cnt_q   <= '0;
            rb_data_q  <= '0;
            rb_valid_q <= 1'b0;
        end else begin
            rb_acc_q   <= rb_acc_d;
            rb_cnt_q   <= rb_cnt_d;
            rb_data_q  <= rb_data_d;
            rb_valid_q <= rb_valid_d;
        end
    end

    // Old chain bit is sampled on every capturing edge; the last bit of the
    // load flushes a partial word so it lands together with done.
    always_comb begin
        rb_acc_d   = rb_acc_q;
        rb_cnt_d   = rb_cnt_q;
        rb_data_d  = rb_data_q;
        rb_valid_d = 1'b0;
        rb_word    = rb_acc_q | (WORD_W'(ccff_tail) << rb_cnt_q);

        if (load_start) begin
            rb_acc_d = '0;
            rb_cnt_d = '0;
        end else if (shift_en_q) begin
            if ((rb_cnt_q == WB_W'(WORD_W - 1)) || (bit_cnt_d == CHAIN_LEN_C)) begin
                rb_data_d  = rb_word;
                rb_valid_d = 1'b1;
                rb_acc_d   = '0;
                rb_cnt_d   = '0;
            end else begin
                rb_acc_d = rb_word;
                rb_cnt_d = rb_cnt_q + WB_W'(1);
            end
        end
    end

    assign rb_data  = rb_data_q;
    assign rb_valid = rb_valid_q;
`else
    // Tail has no consumer without readback.
    logic unused_tail;
    assign unused_tail = &{1'b0, ccff_tail, load_start, 1'b0};
`endif

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Self-checking bench for ccff_bitstream_loader: bit-queue model of the serial stream,
// an external 36-bit chain, and directed load scenarios (readback part under CCFF_READBACK_EN).
`timescale 1ns/1ps
module tb_ccff_bitstream_loader;

    localparam int unsigned WORD_W    = 8;
    localparam int unsigned CHAIN_LEN = 36;
    localparam int unsigned CNT_W     = 16;

    logic              prog_clk     = 1'b0;
    logic              prog_reset_n = 1'b0;
    logic              start        = 1'b0;
    logic              ccff_head, ccff_shift_en, ccff_tail, busy, done;
    logic [CNT_W-1:0]  bit_cnt;
`ifdef CCFF_READBACK_EN
    logic [WORD_W-1:0] rb_data;
    logic              rb_valid;
`endif

    ccff_bitstream_loader_if #(.WORD_W(WORD_W)) bs_if ();

    ccff_bitstream_loader #(
        .WORD_W   (WORD_W),
        .CHAIN_LEN(CHAIN_LEN),
        .CNT_W    (CNT_W)
    ) dut (
        .prog_clk     (prog_clk),
        .prog_reset_n (prog_reset_n),
        .start        (start),
        .bs           (bs_if),
        .ccff_head    (ccff_head),
        .ccff_shift_en(ccff_shift_en),
        .ccff_tail    (ccff_tail),
        .busy         (busy),
        .done         (done),
        .bit_cnt      (bit_cnt)
`ifdef CCFF_READBACK_EN
        ,
        .rb_data      (rb_data),
        .rb_valid     (rb_valid)
`endif
    );

    always #5 prog_clk = ~prog_clk;

    // External configuration chain: new bits enter at the top, tail is bit 0.
    logic [CHAIN_LEN-1:0] chain = '0;
    logic                 preload_req = 1'b0;
    logic [CHAIN_LEN-1:0] preload_val = '0;
    always @(posedge prog_clk) begin
        if (preload_req)        chain <= preload_val;
        else if (ccff_shift_en) chain <= {ccff_head, chain[CHAIN_LEN-1:1]};
    end
    assign ccff_tail = chain[0];

    int errs   = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: the stream is a queue of bits still to appear on ccff_head.
    bit          m_q[$];
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    int          m_cnt = 0;
    int          m_pushed = 0;
    int          shift_cnt = 0;
    int          first_hs_cyc = 0;
    int          n_bits;
    int          qsz;
    logic        exp_ready;
    logic        was_busy;
    logic [7:0]  head_log = '0;
`ifdef CCFF_READBACK_EN
    logic [WORD_W-1:0]    rb_q[$];
    logic [WORD_W-1:0]    rb_log[$];
    logic [CHAIN_LEN-1:0] snap;
`endif

    always @(negedge prog_clk) begin
        cyc++;
        if (!prog_reset_n) begin
            chk("reset_outputs", 64'({busy, done, ccff_shift_en, ccff_head, bs_if.bs_ready, bit_cnt}), 64'(0));
`ifdef CCFF_READBACK_EN
            chk("reset_rb", 64'({rb_valid, rb_data}), 64'(0));
            rb_q.delete();
`endif
            m_q.delete();
            m_busy = 1'b0; m_done = 1'b0; m_cnt = 0; m_pushed = 0;
        end else begin
            qsz       = m_q.size();
            was_busy  = m_busy;
            exp_ready = m_busy && (qsz == 0);
            chk("shift_en", 64'(ccff_shift_en), 64'(qsz != 0));
            chk("bs_ready", 64'(bs_if.bs_ready), 64'(exp_ready));
            chk("bit_cnt", 64'(bit_cnt), 64'(m_cnt));
            chk("busy", 64'(busy), 64'(m_busy));
            chk("done", 64'(done), 64'(m_done));
            if (ccff_shift_en && (qsz != 0)) begin
                chk("head", 64'(ccff_head), 64'(m_q[0]));
                if (m_cnt < 8) head_log[m_cnt[2:0]] = ccff_head;
                void'(m_q.pop_front());
                m_cnt++;
                shift_cnt++;
                if (m_cnt == int'(CHAIN_LEN)) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end
`ifdef CCFF_READBACK_EN
            if (rb_valid) begin
                if (rb_q.size() == 0) begin
                    chk("rb_valid_extra", 64'(rb_valid), 64'(0));
                end else begin
                    chk("rb_data", 64'(rb_data), 64'(rb_q[0]));
                    rb_log.push_back(rb_data);
                    void'(rb_q.pop_front());
                    chk("rb_done_align", 64'(done), 64'(rb_q.size() == 0));
                end
            end
`endif
            if (exp_ready && bs_if.bs_valid) begin
                n_bits = (int'(CHAIN_LEN) - m_pushed < int'(WORD_W)) ? int'(CHAIN_LEN) - m_pushed : int'(WORD_W);
                if (m_pushed == 0) first_hs_cyc = cyc;
                for (int b = 0; b < n_bits; b++) m_q.push_back(bs_if.bs_data[b]);
                m_pushed += n_bits;
            end
            if (start && !was_busy) begin
                m_busy = 1'b1; m_done = 1'b0; m_cnt = 0; m_pushed = 0; shift_cnt = 0;
                head_log = '0;
`ifdef CCFF_READBACK_EN
                // Old chain bits emerge at the tail in index order.
                snap = chain;
                rb_q.delete();
                rb_log.delete();
                for (int w = 0; w * int'(WORD_W) < int'(CHAIN_LEN); w++) rb_q.push_back(WORD_W'(snap >> (w * WORD_W)));
`endif
            end
        end
    end

    // Stimulus helpers; all start and end at posedge + 1.
    logic [WORD_W-1:0] words[6];
    int                gaps[6];
    int                nwords;
    logic              abort = 1'b0;

    task automatic send_words();
        int budget;
        logic hs;
        for (int i = 0; i < nwords; i++) begin
            if (abort) break;
            repeat (gaps[i]) begin @(posedge prog_clk); #1; end
            bs_if.bs_data  = words[i];
            bs_if.bs_valid = 1'b1;
            hs = 1'b0;
            budget = 0;
            while (!hs && !abort && budget < 200) begin
                @(negedge prog_clk);
                if (bs_if.bs_ready && prog_reset_n) hs = 1'b1;
                @(posedge prog_clk); #1;
                budget++;
            end
            bs_if.bs_valid = 1'b0;
            if (!abort) chk("handshake", 64'(hs), 64'(1));
        end
    endtask

    task automatic start_pulse();
        start = 1'b1;
        @(posedge prog_clk); #1;
        start = 1'b0;
        @(negedge prog_clk); #1;
        chk("start_busy", 64'(busy), 64'(1));
        chk("start_done_clr", 64'(done), 64'(0));
        chk("start_cnt0", 64'(bit_cnt), 64'(0));
        @(posedge prog_clk); #1;
    endtask

    task automatic wait_done(output int at_cyc);
        int k = 0;
        at_cyc = -1;
        while (k < 300) begin
            @(negedge prog_clk); #1;
            if (done) begin at_cyc = cyc; break; end
            k++;
        end
        chk("done_seen", 64'(done), 64'(1));
    endtask

    task automatic wait_bits(input int n);
        int k = 0;
        while (k < 300) begin
            @(negedge prog_clk); #1;
            if (int'(bit_cnt) == n) break;
            k++;
        end
        chk("bits_reached", 64'(bit_cnt), 64'(n));
    endtask

    task automatic set_std(input logic [WORD_W-1:0] last);
        words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF; words[3] = 8'h00; words[4] = last;
        for (int i = 0; i < 6; i++) gaps[i] = 0;
        nwords = 5;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcyc;
        bs_if.bs_data  = '0;
        bs_if.bs_valid = 1'b0;

        // Reset state
        repeat (3) @(posedge prog_clk);
        #1;
        chk("reset_head", 64'(ccff_head), 64'(0));
        prog_reset_n = 1'b1;
        @(posedge prog_clk); #1;

        // Full back-to-back load
        set_std(8'h09);
        start_pulse();
        send_words();
        wait_done(dcyc);
        chk("load_latency", 64'(dcyc - first_hs_cyc), 64'(41));
        chk("shift_count", 64'(shift_cnt), 64'(36));
        chk("head_first8", 64'(head_log), 64'(8'hA5));
        chk("final_bit_cnt", 64'(bit_cnt), 64'(36));
        chk("chain_full", 64'(chain), 64'(36'h9_00FF_3CA5));
        @(posedge prog_clk); #1;

        // Stall between words 2 and 3 (from DONE, so also a restart)
        set_std(8'h09);
        gaps[2] = 13;
        start_pulse();
        send_words();
        wait_done(dcyc);
        chk("stall_shift_count", 64'(shift_cnt), 64'(36));
        chk("chain_stall", 64'(chain), 64'(36'h9_00FF_3CA5));
        @(posedge prog_clk); #1;

        // Partial last word with a surplus word left pending
        set_std(8'hF6);
        start_pulse();
        send_words();
        bs_if.bs_data  = 8'h55;
        bs_if.bs_valid = 1'b1;
        wait_done(dcyc);
        repeat (6) begin
            @(negedge prog_clk); #1;
            chk("surplus_stalled", 64'(bs_if.bs_ready), 64'(0));
        end
        chk("chain_partial", 64'(chain), 64'(36'h6_00FF_3CA5));
        @(posedge prog_clk); #1;
        bs_if.bs_valid = 1'b0;

        // Reset in the middle of shifting
        set_std(8'h09);
        start_pulse();
        fork
            send_words();
            begin
                wait_bits(13);
                #1;
                prog_reset_n = 1'b0;
                abort = 1'b1;
                #1;
                chk("async_shift_en", 64'(ccff_shift_en), 64'(0));
                chk("async_busy", 64'(busy), 64'(0));
                chk("async_bit_cnt", 64'(bit_cnt), 64'(0));
                repeat (2) @(posedge prog_clk);
                #1;
                prog_reset_n = 1'b1;
            end
        join
        abort = 1'b0;
        bs_if.bs_valid = 1'b0;
        @(posedge prog_clk); #1;
        start_pulse();
        send_words();
        wait_done(dcyc);
        chk("chain_after_reset", 64'(chain), 64'(36'h9_00FF_3CA5));
        @(posedge prog_clk); #1;

        // Start while busy is ignored
        set_std(8'h09);
        start_pulse();
        fork
            send_words();
            begin
                wait_bits(20);
                @(posedge prog_clk); #1;
                start = 1'b1;
                @(posedge prog_clk); #1;
                start = 1'b0;
                chk("busy_start_ignored", 64'(busy), 64'(1));
            end
        join
        wait_done(dcyc);
        chk("busy_start_cnt", 64'(bit_cnt), 64'(36));
        chk("busy_start_shifts", 64'(shift_cnt), 64'(36));
        @(posedge prog_clk); #1;

`ifdef CCFF_READBACK_EN
        // Readback of a preloaded chain
        preload_val = 36'h5_1234_ABCD;
        preload_req = 1'b1;
        @(posedge prog_clk); #1;
        preload_req = 1'b0;
        set_std(8'h09);
        start_pulse();
        send_words();
        wait_done(dcyc);
        chk("rb_at_done", 64'(rb_valid), 64'(1));
        chk("rb_count", 64'(rb_log.size()), 64'(5));
        if (rb_log.size() == 5) begin
            chk("rb_w0", 64'(rb_log[0]), 64'(8'hCD));
            chk("rb_w1", 64'(rb_log[1]), 64'(8'hAB));
            chk("rb_w2", 64'(rb_log[2]), 64'(8'h34));
            chk("rb_w3", 64'(rb_log[3]), 64'(8'h12));
            chk("rb_w4", 64'(rb_log[4]), 64'(8'h05));
        end
        chk("chain_rb", 64'(chain), 64'(36'h9_00FF_3CA5));
        @(posedge prog_clk); #1;
`endif

        repeat (3) @(posedge prog_clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
